// File: rtl/riscv_aes_regfile_pkg.sv
// Shared types for the AES context register file: FSM states and bank-select codes.
package riscv_aes_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } aes_state_e;

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_KEY  = 2'b01;

endpackage

// File: rtl/riscv_aes_word_bank.sv
// One bank of context words with a per-word valid mask, bulk clear and range check.
module riscv_aes_word_bank #(
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wen_i,
    input  logic [ADDR_WIDTH-1:0]           waddr_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic                            clear_i,
    input  logic                            mask_clr_i,
    input  logic                            load_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] load_data_i,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] words_o,
    output logic                            in_range_o,
    output logic                            full_next_o
);

    logic [DATA_WIDTH-1:0] words_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] words_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]  mask_q, mask_d, hit;

    always_comb begin
        in_range_o = (32'(waddr_i) < NUM_WORDS);
        hit = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            hit[i] = wen_i && (32'(waddr_i) == i);
        end
        // Fullness includes a same-cycle write so a start can race its last word.
        full_next_o = !clear_i && (&(mask_q | hit));

        if (load_i)                    mask_d = '1;
        else if (clear_i || mask_clr_i) mask_d = '0;
        else                           mask_d = mask_q | hit;

        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (load_i)      words_d[i] = load_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            else if (hit[i]) words_d[i] = wdata_i;
            else             words_d[i] = words_q[i];
            words_o[i*DATA_WIDTH +: DATA_WIDTH] = words_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
        end else begin
            mask_q <= mask_d;
            for (int unsigned i = 0; i < NUM_WORDS; i++) words_q[i] <= words_d[i];
        end
    end

endmodule

// File: rtl/riscv_aes_ctx_regfile.sv
// AES context register file: data/key banks, launch/result handshake and error pulses.
// Optional macro AES_RESULT_CHAIN_EN copies each captured result back into the data bank.
module riscv_aes_ctx_regfile #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_DATA_WORDS = 4,
    parameter int unsigned NUM_KEY_WORDS  = 4,
    parameter int unsigned ADDR_WIDTH     = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 test_en_i,
    input  logic [ADDR_WIDTH-1:0]                waddr_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i,
    input  logic                                 wen_i,
    input  logic [1:0]                           wsel_i,
    input  logic                                 clear_i,
    input  logic                                 aes_start_i,
    input  logic                                 aes_done_i,
    input  logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] aes_result_i,
    input  logic                                 res_ack_i,
    output logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] data_o,
    output logic [NUM_KEY_WORDS*DATA_WIDTH-1:0]  key_o,
    output logic                                 aes_start_o,
    output logic                                 aes_busy_o,
    output logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] result_o,
    output logic                                 result_valid_o,
    output logic                                 err_o
);

    import riscv_aes_regfile_pkg::*;

    aes_state_e                          state_q;
    logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] result_q;
    logic start_q, err_q;
    logic busy, wr_data, wr_key, wr_bad, clr_ok, start_ok, capture, err_d, data_load;
    logic d_in_range, k_in_range, d_full_next, k_full_next;
    logic unused_test_en;

    assign unused_test_en = test_en_i;

    assign busy     = (state_q == ST_BUSY);
    assign wr_data  = wen_i && !busy && (wsel_i == SEL_DATA);
    assign wr_key   = wen_i && !busy && (wsel_i == SEL_KEY);
    assign wr_bad   = wen_i && !busy && !((wsel_i == SEL_DATA && d_in_range) ||
                                          (wsel_i == SEL_KEY  && k_in_range));
    assign clr_ok   = clear_i && !busy;
    assign start_ok = aes_start_i && !busy && d_full_next && k_full_next;
    assign capture  = busy && aes_done_i;
    assign err_d    = (busy && (wen_i || aes_start_i || clear_i)) || wr_bad ||
                      (aes_start_i && !busy && !start_ok);

`ifdef AES_RESULT_CHAIN_EN
    assign data_load = capture;
`else
    assign data_load = 1'b0;
`endif

    riscv_aes_word_bank #(
        .NUM_WORDS (NUM_DATA_WORDS),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_data_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen_i      (wr_data),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .clear_i    (clr_ok),
        .mask_clr_i (start_ok),
        .load_i     (data_load),
        .load_data_i(aes_result_i),
        .words_o    (data_o),
        .in_range_o (d_in_range),
        .full_next_o(d_full_next)
    );

    riscv_aes_word_bank #(
        .NUM_WORDS (NUM_KEY_WORDS),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_key_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen_i      (wr_key),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .clear_i    (clr_ok),
        .mask_clr_i (1'b0),
        .load_i     (1'b0),
        .load_data_i('0),
        .words_o    (key_o),
        .in_range_o (k_in_range),
        .full_next_o(k_full_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            start_q <= start_ok;
            err_q   <= err_d;
            if (capture) result_q <= aes_result_i;
            case (state_q)
                ST_IDLE: if (start_ok) state_q <= ST_BUSY;
                ST_BUSY: if (aes_done_i) state_q <= ST_DONE;
                // A new start in DONE doubles as the result acknowledge.
                ST_DONE: begin
                    if (start_ok)       state_q <= ST_BUSY;
                    else if (res_ack_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign aes_start_o    = start_q;
    assign err_o          = err_q;
    assign aes_busy_o     = (state_q == ST_BUSY);
    assign result_valid_o = (state_q == ST_DONE);
    assign result_o       = result_q;

endmodule
